branch_cmp_pred: RTL and testbench
==================================

# branch_cmp_pred

Parametrised branch-resolution and prediction unit for the pipelined MIPS datapath. It evaluates the branch condition in ID from forwarded register operands. It also holds a pattern history table (PHT) of 2-bit saturating counters that supplies a taken/not-taken prediction to IF. On resolution it reports a mispredict to the hazard/flush logic and updates the PHT and two performance counters.

## Interface
- `WIDTH`, 32: operand width in bits.
- `PHT_DEPTH`, 16: number of PHT entries; power of two, at least 2.
- `IDX_LSB`, 2: lowest PC bit used for the PHT index. Index = `pc[IDX_LSB +: log2(PHT_DEPTH)]`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `a`  in  WIDTH  first operand (rs, after forwarding).
- `b`  in  WIDTH  second operand (rt, after forwarding).
- `op`  in  4  condition select; encoding under Operation.
- `pred_pc`  in  32  PC of the instruction currently in IF.
- `pred_taken`  out  1  prediction for `pred_pc`; combinational read of the PHT.
- `resolve_valid`  in  1  a branch in ID resolves this cycle; low during stalls and bubbles.
- `resolve_pc`  in  32  PC of the resolving branch.
- `resolve_pred`  in  1  prediction that branch received in IF, carried down the pipe.
- `br`  out  1  condition result; combinational, independent of `resolve_valid`.
- `mispredict`  out  1  combinational: `resolve_valid & is_branch & (br != resolve_pred)`.
- `branch_cnt`  out  32  count of resolved branches.
- `mispred_cnt`  out  32  count of mispredicts.

## Operation
- `op` encoding. Signed compares use WIDTH-bit two's complement. "Zero" below is the value 0.
  - 0000: none, `br`=0.
  - 0001: `a`==`b`.
  - 0010: `a`!=`b`.
  - 0011: `a`<=0 signed.
  - 0100: `a`>0 signed.
  - 0101: `a`<0 signed.
  - 0110: `a`>=0 signed.
  - 0111: `a`<`b` signed.
  - 1000: `a`>=`b` signed.
  - 1001: `a`<`b` unsigned.
  - 1010: `a`>=`b` unsigned.
  - 1011–1111: `br`=0.
- `is_branch` is true for `op` 0001–1010 only. With an invalid `op`, `resolve_valid` has no effect: no PHT update, no count, `mispredict`=0.
- PHT counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Prediction = counter bit 1.
- Update when `resolve_valid & is_branch`: the entry at `resolve_pc` index increments if `br`=1 and decrements if `br`=0. It saturates at 11 and 00.
- `branch_cnt` increments on every update. `mispred_cnt` increments when `mispredict`=1. Both saturate at 0xFFFFFFFF and do not wrap.

## Timing
- `br`, `mispredict` and `pred_taken` are combinational with zero latency. Updates to the PHT and counters take effect at the next rising edge.
- Same index read and written in one cycle: `pred_taken` shows the pre-update value. The new value is visible the cycle after the edge; no bypass.
- Reset is asserted asynchronously and immediately sets:
  - every PHT entry to 01,
  - `branch_cnt`=0 and `mispred_cnt`=0,
  - `pred_taken`=0 (reset value).
- `br` is combinational and does not depend on reset.
- Reset during a resolve cycle: the update is lost. Reset dominates.
- PC bits outside the index are ignored, so aliasing between branches is permitted.
- `resolve_valid` held high for N cycles on the same branch produces N updates. The pipeline must deassert it during stalls.

## Test plan
- Reset, then read all indices → `pred_taken`=0 everywhere; both counters 0.
- `op`=0111, `a`=0xFFFFFFFF, `b`=1 → `br`=1. With `op`=1001 and the same operands → `br`=0. With `op`=0101, `a`=0x80000000 → `br`=1.
- Resolve the branch at PC 0x3004 taken three times with `resolve_pred` matching the PHT each time. Required:
  - prediction sequence is 0, 1, 1,
  - the counter saturates at 11,
  - `mispred_cnt`=1 (only the first resolve mispredicts),
  - `branch_cnt`=3.
- `pred_pc` = `resolve_pc` = 0x3008, entry at 01, resolve taken → `pred_taken`=0 in the resolving cycle and 1 in the next cycle.
- `resolve_valid`=1 with `op`=1100 → no PHT change, counters unchanged, `mispredict`=0.
- Force `mispred_cnt` to 0xFFFFFFFF and resolve a mispredict → the count holds at 0xFFFFFFFF. Assert `reset` mid-cycle → all counts clear before the next edge.

Source files
------------

// File: rtl/branch_cmp_pred.sv
// Branch condition evaluation in ID plus a 2-bit saturating-counter pattern history
// table that predicts for IF; reports mispredicts and keeps saturating perf counters.
module branch_cmp_pred #(
    parameter int WIDTH     = 32,
    parameter int PHT_DEPTH = 16,
    parameter int IDX_LSB   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic [31:0]      pred_pc,
    output logic             pred_taken,
    input  logic             resolve_valid,
    input  logic [31:0]      resolve_pc,
    input  logic             resolve_pred,
    output logic             br,
    output logic             mispredict,
    output logic [31:0]      branch_cnt,
    output logic [31:0]      mispred_cnt
);
    localparam int IDX_W = $clog2(PHT_DEPTH);

    logic [1:0]       pht [PHT_DEPTH];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic [1:0]       res_ctr;
    logic             is_branch;
    logic             update;
    logic             a_neg;
    logic             a_zero;
    logic             unused_pc_bits;

    assign pred_idx = pred_pc[IDX_LSB +: IDX_W];
    assign res_idx  = resolve_pc[IDX_LSB +: IDX_W];
    assign res_ctr  = pht[res_idx];

    // Upper/lower PC bits outside the index are deliberately ignored (aliasing allowed).
    assign unused_pc_bits = ^{pred_pc, resolve_pc};

    assign a_neg  = a[WIDTH-1];
    assign a_zero = ~|a;

    always_comb begin
        br        = 1'b0;
        is_branch = 1'b1;
        case (op)
            4'b0001: br = (a == b);
            4'b0010: br = (a != b);
            4'b0011: br = a_neg | a_zero;
            4'b0100: br = ~a_neg & ~a_zero;
            4'b0101: br = a_neg;
            4'b0110: br = ~a_neg;
            4'b0111: br = ($signed(a) < $signed(b));
            4'b1000: br = ($signed(a) >= $signed(b));
            4'b1001: br = (a < b);
            4'b1010: br = (a >= b);
            default: begin
                br        = 1'b0;
                is_branch = 1'b0;
            end
        endcase
    end

    assign update     = resolve_valid & is_branch;
    assign mispredict = update & (br != resolve_pred);

    // Read is the registered array value, so a same-cycle update is not bypassed.
    assign pred_taken = pht[pred_idx][1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pht <= '{default: 2'b01};
        end else if (update) begin
            if (br && res_ctr != 2'b11) begin
                pht[res_idx] <= res_ctr + 2'b01;
            end else if (!br && res_ctr != 2'b00) begin
                pht[res_idx] <= res_ctr - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (update && branch_cnt != 32'hFFFF_FFFF) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredict && mispred_cnt != 32'hFFFF_FFFF) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_cmp_pred.sv
// Directed and randomised checks of branch_cmp_pred against a small behavioural model.
module tb_branch_cmp_pred;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic        resolve_pred;
    logic        br;
    logic        mispredict;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    logic [1:0]  pht_m [16];
    logic [31:0] bcnt_m;
    logic [31:0] mcnt_m;

    branch_cmp_pred #(.WIDTH(32), .PHT_DEPTH(16), .IDX_LSB(2)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .op(op),
        .pred_pc(pred_pc), .pred_taken(pred_taken),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .resolve_pred(resolve_pred),
        .br(br), .mispredict(mispredict),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    function automatic logic br_m(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        sx = x;
        sy = y;
        case (o)
            4'd1:    return x == y;
            4'd2:    return x != y;
            4'd3:    return sx <= 0;
            4'd4:    return sx > 0;
            4'd5:    return sx < 0;
            4'd6:    return sx >= 0;
            4'd7:    return sx < sy;
            4'd8:    return sx >= sy;
            4'd9:    return x < y;
            4'd10:   return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        logic [0:2] seq_pred;
        logic [0:2] seq_misp;
        logic [3:0] op_v;
        logic [31:0] a_v, b_v, pc_v, ppc_v;
        logic rv_v, rp_v, br_v, upd_v, misp_v;

        reset = 1'b1;
        a = '0; b = '0; op = '0;
        pred_pc = '0; resolve_valid = 1'b0; resolve_pc = '0; resolve_pred = 1'b0;
        repeat (2) tick();
        reset = 1'b0;

        // Reset state: every index predicts not-taken, counters zero.
        for (int i = 0; i < 16; i++) begin
            pred_pc = 32'(i) << 2;
            push(32'd0);
            #1 chk("reset_pred", {31'd0, pred_taken});
        end
        push(32'd0); chk("reset_branch_cnt", branch_cnt);
        push(32'd0); chk("reset_mispred_cnt", mispred_cnt);

        // Comparator corner cases.
        op = 4'b0111; a = 32'hFFFF_FFFF; b = 32'd1; push(32'd1);
        #1 chk("slt_neg", {31'd0, br});
        op = 4'b1001; push(32'd0);
        #1 chk("ult_big", {31'd0, br});
        op = 4'b0101; a = 32'h8000_0000; push(32'd1);
        #1 chk("ltz_min", {31'd0, br});
        op = 4'b0011; a = 32'd0; push(32'd1);
        #1 chk("lez_zero", {31'd0, br});
        op = 4'b0100; push(32'd0);
        #1 chk("gtz_zero", {31'd0, br});
        op = 4'b1111; a = 32'd3; b = 32'd3; push(32'd0);
        #1 chk("invalid_op", {31'd0, br});

        // Branch at 0x3004 resolved taken three times.
        seq_pred = 3'b011;
        seq_misp = 3'b100;
        tick();
        for (int k = 0; k < 3; k++) begin
            pred_pc = 32'h3004; resolve_pc = 32'h3004;
            op = 4'b0001; a = 32'd5; b = 32'd5;
            resolve_valid = 1'b1; resolve_pred = seq_pred[k];
            push({31'd0, seq_pred[k]});
            push({31'd0, seq_misp[k]});
            #2;
            chk("seq_pred", {31'd0, pred_taken});
            chk("seq_misp", {31'd0, mispredict});
            tick();
        end
        resolve_valid = 1'b0;
        push(32'd3); chk("seq_branch_cnt", branch_cnt);
        push(32'd1); chk("seq_mispred_cnt", mispred_cnt);
        push(32'd1); chk("seq_pred_after", {31'd0, pred_taken});
        // One not-taken step from saturation must still predict taken.
        b = 32'd6; resolve_valid = 1'b1; resolve_pred = 1'b1;
        push(32'd1); #2 chk("sat_nt_misp", {31'd0, mispredict});
        tick();
        resolve_valid = 1'b0;
        push(32'd1); chk("sat_pred_still_t", {31'd0, pred_taken});
        push(32'd4); chk("sat_branch_cnt", branch_cnt);
        push(32'd2); chk("sat_mispred_cnt", mispred_cnt);

        // Same index read and written: no bypass.
        pred_pc = 32'h3008; resolve_pc = 32'h3008;
        op = 4'b0001; a = 32'd9; b = 32'd9;
        resolve_valid = 1'b1; resolve_pred = 1'b0;
        push(32'd0); push(32'd1);
        #2 chk("nobypass_pred_now", {31'd0, pred_taken});
        chk("nobypass_misp", {31'd0, mispredict});
        tick();
        resolve_valid = 1'b0;
        push(32'd1); chk("nobypass_pred_next", {31'd0, pred_taken});
        push(32'd5); chk("nobypass_branch_cnt", branch_cnt);
        push(32'd3); chk("nobypass_mispred_cnt", mispred_cnt);

        // Invalid op with resolve_valid: nothing changes.
        op = 4'b1100; resolve_valid = 1'b1; resolve_pred = 1'b1;
        push(32'd0); #2 chk("inv_misp", {31'd0, mispredict});
        tick();
        resolve_valid = 1'b0;
        push(32'd1); chk("inv_pred", {31'd0, pred_taken});
        push(32'd5); chk("inv_branch_cnt", branch_cnt);
        push(32'd3); chk("inv_mispred_cnt", mispred_cnt);

        // Aliasing: only the index bits matter.
        pred_pc = 32'h7008; push(32'd1);
        #1 chk("alias_pred", {31'd0, pred_taken});

        // Mispredict counter saturation.
        tick();
        force dut.mispred_cnt = 32'hFFFF_FFFF;
        #1 release dut.mispred_cnt;
        resolve_pc = 32'h3010; op = 4'b0001; a = 32'd1; b = 32'd2;
        resolve_valid = 1'b1; resolve_pred = 1'b1;
        push(32'd1); #1 chk("msat_misp", {31'd0, mispredict});
        tick();
        push(32'hFFFF_FFFF); chk("msat_cnt1", mispred_cnt);
        tick();
        resolve_valid = 1'b0;
        push(32'hFFFF_FFFF); chk("msat_cnt2", mispred_cnt);
        push(32'd7); chk("msat_branch_cnt", branch_cnt);

        // Reset asserted mid-cycle during a resolve.
        pred_pc = 32'h3008; resolve_pc = 32'h3008;
        op = 4'b0001; a = 32'd4; b = 32'd4; resolve_valid = 1'b1; resolve_pred = 1'b1;
        #2 reset = 1'b1;
        push(32'd0); push(32'd0); push(32'd0);
        #1 chk("rst_branch_cnt", branch_cnt);
        chk("rst_mispred_cnt", mispred_cnt);
        chk("rst_pred", {31'd0, pred_taken});
        tick();
        reset = 1'b0; resolve_valid = 1'b0;
        push(32'd0); push(32'd0);
        #1 chk("rst_lost_update", {31'd0, pred_taken});
        chk("rst_branch_hold", branch_cnt);

        // Randomised resolves against the model.
        for (int i = 0; i < 16; i++) pht_m[i] = 2'b01;
        bcnt_m = '0;
        mcnt_m = '0;
        for (int n = 0; n < 60; n++) begin
            op_v  = 4'($urandom_range(0, 15));
            a_v   = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            b_v   = ($urandom_range(0, 3) == 0) ? a_v : $urandom;
            pc_v  = $urandom & 32'h0000_003C;
            ppc_v = ($urandom_range(0, 1) == 1) ? pc_v : ($urandom & 32'h0000_00FC);
            rv_v  = ($urandom_range(0, 3) != 0);
            rp_v  = 1'($urandom_range(0, 1));
            op = op_v; a = a_v; b = b_v; pred_pc = ppc_v;
            resolve_pc = pc_v; resolve_valid = rv_v; resolve_pred = rp_v;
            br_v   = br_m(op_v, a_v, b_v);
            upd_v  = rv_v & (op_v >= 4'd1) & (op_v <= 4'd10);
            misp_v = upd_v & (br_v != rp_v);
            push({31'd0, br_v});
            push({31'd0, misp_v});
            push({31'd0, pht_m[ppc_v[5:2]][1]});
            #2;
            chk("rnd_br", {31'd0, br});
            chk("rnd_misp", {31'd0, mispredict});
            chk("rnd_pred", {31'd0, pred_taken});
            tick();
            if (upd_v) begin
                if (br_v && pht_m[pc_v[5:2]] != 2'b11) pht_m[pc_v[5:2]] = pht_m[pc_v[5:2]] + 2'b01;
                if (!br_v && pht_m[pc_v[5:2]] != 2'b00) pht_m[pc_v[5:2]] = pht_m[pc_v[5:2]] - 2'b01;
                bcnt_m = bcnt_m + 32'd1;
            end
            if (misp_v) mcnt_m = mcnt_m + 32'd1;
            push(bcnt_m); chk("rnd_branch_cnt", branch_cnt);
            push(mcnt_m); chk("rnd_mispred_cnt", mispred_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
